// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch and data access.
// Data wins conflicts; a streak counter bounds how long fetch can be starved.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

  state_t                state, state_nxt;
  logic [STREAK_W-1:0]   dm_streak, dm_streak_nxt;
  logic                  mem_req_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;
  logic                  if_ack_nxt, dm_ack_nxt;
  logic                  if_elig, dm_elig;

  // A request is not eligible in the cycle its ack is presented.
  assign if_elig  = if_req & ~if_ack;
  assign dm_elig  = dm_req & ~dm_ack;
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dm_streak <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      state     <= state_nxt;
      dm_streak <= dm_streak_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      if_ack    <= if_ack_nxt;
      dm_ack    <= dm_ack_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dm_streak_nxt = dm_streak;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_ack_nxt    = 1'b0;
    dm_ack_nxt    = 1'b0;

    case (state)
      IDLE: begin
        // Data wins unless fetch has already waited out the full streak.
        if (dm_elig && (!if_elig || (dm_streak < STREAK_MAX))) begin
          state_nxt     = GNT_DM;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
          if (!if_elig) begin
            dm_streak_nxt = '0;
          end else if (dm_streak != STREAK_MAX) begin
            dm_streak_nxt = dm_streak + STREAK_W'(1);
          end
        end else if (if_elig) begin
          state_nxt     = GNT_IF;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          dm_streak_nxt = '0;
        end
      end
      GNT_IF: begin
        if (mem_ready) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          mem_we_nxt   = 1'b0;
          if_rdata_nxt = mem_rdata;
          if_ack_nxt   = 1'b1;
        end
      end
      GNT_DM: begin
        if (mem_ready) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          dm_ack_nxt  = 1'b1;
          if (!mem_we) begin
            dm_rdata_nxt = mem_rdata;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int checks;
  int failures;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DM_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port, what was latched, what is reported.
  int          owner;      // 0 none, 1 fetch, 2 data
  int          streak;
  logic        e_req, e_we, e_if_ack, e_dm_ack;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;

  task automatic model_reset();
    owner = 0; streak = 0;
    e_req = 0; e_we = 0; e_if_ack = 0; e_dm_ack = 0;
    e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0;
  endtask

  task automatic model_step();
    bit want_if, want_dm, give_dm;
    bit new_if_ack, new_dm_ack;
    if (rst) begin
      model_reset();
      return;
    end
    new_if_ack = 0;
    new_dm_ack = 0;
    if (owner == 0) begin
      want_if = if_req && !e_if_ack;
      want_dm = dm_req && !e_dm_ack;
      give_dm = want_dm && (!want_if || streak < MAX_STREAK);
      if (give_dm) begin
        owner = 2; e_req = 1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
        streak = want_if ? ((streak + 1 > MAX_STREAK) ? MAX_STREAK : streak + 1) : 0;
      end else if (want_if) begin
        owner = 1; e_req = 1; e_we = 0; e_addr = if_addr; streak = 0;
      end
    end else if (mem_ready) begin
      if (owner == 1) begin
        e_if_rdata = mem_rdata;
        new_if_ack = 1;
      end else begin
        if (!e_we) e_dm_rdata = mem_rdata;
        new_dm_ack = 1;
      end
      owner = 0; e_req = 0; e_we = 0;
    end
    e_if_ack = new_if_ack;
    e_dm_ack = new_dm_ack;
  endtask

  task automatic clk_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    clk_wait();
    clk_wait();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_ack, dm_ack, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_ack, dm_ack, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    clk_wait();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c0: stall=%b mem_req=%b expected 1 0", if_stall, mem_req);
    end
    clk_wait();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_mem: req=%b we=%b addr=%h busy=%b expected 1 0 10 1",
               mem_req, mem_we, mem_addr, busy);
    end
    clk_wait();
    mem_ready = 0; mem_rdata = 0;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_stall !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack: ack=%b rdata=%h stall=%b mem_req=%b expected 1 deadbeef 0 0",
               if_ack, if_rdata, if_stall, mem_req);
    end
    clk_wait();
    if_req = 0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || if_ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_no_regrant: mem_req=%b ack=%b busy=%b expected 0 0 0", mem_req, if_ack, busy);
    end
  endtask

  task automatic test_store_load();
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h1234;
    clk_wait();
    mem_ready = 1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin
      failures++;
      $display("FAIL store_mem: req=%b we=%b addr=%h wdata=%h expected 1 1 40 1234",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    clk_wait();
    mem_ready = 0; dm_req = 0;
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'h0) begin
      failures++;
      $display("FAIL store_ack: ack=%b rdata=%h expected 1 0", dm_ack, dm_rdata);
    end
    clk_wait();
    dm_req = 1; dm_we = 0; dm_addr = 32'h40; dm_wdata = 32'hFFFF;
    clk_wait();
    mem_ready = 1; mem_rdata = 32'h1234;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL load_mem: req=%b we=%b addr=%h expected 1 0 40", mem_req, mem_we, mem_addr);
    end
    clk_wait();
    mem_ready = 0; mem_rdata = 0; dm_req = 0;
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'h1234) begin
      failures++;
      $display("FAIL load_ack: ack=%b rdata=%h expected 1 1234", dm_ack, dm_rdata);
    end
    clk_wait();
  endtask

  task automatic test_conflict();
    int cnt = 0, ngr = 0, ifst = 0, dmst = 0, dm_ack_cyc = -1, if_ack_cyc = -1;
    logic [31:0] first_addr = 0, second_addr = 0;
    if_req = 1; if_addr = 32'h100;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 30 && if_ack_cyc < 0; c++) begin
      if (dm_ack) dm_req = 0;
      if (mem_req) cnt++; else cnt = 0;
      mem_ready = (cnt == 3);
      if (mem_req && cnt == 1) begin
        if (ngr == 0) first_addr = mem_addr; else second_addr = mem_addr;
        ngr++;
      end
      @(negedge clk);
      if (if_stall) ifst++;
      if (dm_stall) dmst++;
      if (dm_ack) dm_ack_cyc = c;
      if (if_ack) if_ack_cyc = c;
      clk_wait();
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
    checks++;
    if (first_addr !== 32'h200 || second_addr !== 32'h100) begin
      failures++;
      $display("FAIL conflict_order: got %h,%h expected 200,100", first_addr, second_addr);
    end
    checks++;
    if (dm_ack_cyc != 4 || if_ack_cyc != 8) begin
      failures++;
      $display("FAIL conflict_acks: dm at %0d if at %0d expected 4 8", dm_ack_cyc, if_ack_cyc);
    end
    checks++;
    if (ifst != 8 || dmst != 4) begin
      failures++;
      $display("FAIL conflict_stalls: if=%0d dm=%0d expected 8 4", ifst, dmst);
    end
    clk_wait();
  endtask

  task automatic test_wait_states();
    int bad = 0, acks = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hAAAA5555;
    clk_wait();
    for (int i = 0; i < 10; i++) begin
      dm_addr = $urandom; dm_wdata = $urandom; mem_ready = 0;
      @(negedge clk);
      if (mem_addr !== 32'h80 || mem_wdata !== 32'hAAAA5555 || mem_req !== 1'b1 ||
          dm_ack !== 1'b0 || dm_stall !== 1'b1) bad++;
      clk_wait();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wait_hold: %0d bad wait cycles expected 0", bad);
    end
    mem_ready = 1;
    clk_wait();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (dm_ack) dm_req = 0;
      @(negedge clk);
      if (dm_ack) acks++;
      clk_wait();
    end
    checks++;
    if (acks != 1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL wait_ack: acks=%0d mem_req=%b expected 1 0", acks, mem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    if_req = 1; if_addr = 32'h20;
    clk_wait();
    mem_ready = 0;
    clk_wait();
    rst = 1; mem_ready = 1; mem_rdata = 32'h5;
    clk_wait();
    rst = 0; mem_ready = 0; if_req = 0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h0 || busy !== 1'b0 || dm_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: mem_req=%b ack=%b if_rdata=%h busy=%b dm_rdata=%h expected 0 0 0 0 0",
               mem_req, if_ack, if_rdata, busy, dm_rdata);
    end
    clk_wait();
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_ack: ack=%b mem_req=%b expected 0 0", if_ack, mem_req);
    end
    clk_wait();
  endtask

  task automatic test_random();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 199) == 0);
      if (if_req && if_ack) begin
        if ($urandom_range(0, 1) == 0) if_req = 0; else if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req && dm_ack) begin
        if ($urandom_range(0, 1) == 0) dm_req = 0;
        else begin dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; end
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {e_req, e_we, e_addr, e_wdata}) begin
          failures++;
          $display("FAIL rand_mem c=%0d: got %b %b %h %h expected %b %b %h %h", c,
                   mem_req, mem_we, mem_addr, mem_wdata, e_req, e_we, e_addr, e_wdata);
        end
        checks++;
        if ({if_ack, dm_ack, if_rdata, dm_rdata} !== {e_if_ack, e_dm_ack, e_if_rdata, e_dm_rdata}) begin
          failures++;
          $display("FAIL rand_resp c=%0d: got %b %b %h %h expected %b %b %h %h", c,
                   if_ack, dm_ack, if_rdata, dm_rdata, e_if_ack, e_dm_ack, e_if_rdata, e_dm_rdata);
        end
        checks++;
        if ({busy, if_stall, dm_stall} !== {owner != 0, if_req & ~e_if_ack, dm_req & ~e_dm_ack}) begin
          failures++;
          $display("FAIL rand_status c=%0d: got %b%b%b expected %b%b%b", c, busy, if_stall, dm_stall,
                   owner != 0, if_req & ~e_if_ack, dm_req & ~e_dm_ack);
        end
      end
      model_step();
      clk_wait();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_store_load();
    test_conflict();
    test_wait_states();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
